// File: rtl/mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Memory stage that sits between EXE_Stage_Reg and MEM_Stage_Reg.  A 32-bit
// load or store is split into two 16-bit accesses on an external SRAM: the low
// halfword first, then the high halfword.  Each half-access is held on the
// SRAM bus for ACC_CYCLES cycles.  While a transaction is in flight, ready is
// low; the pipeline uses ~ready as its global freeze, so all *_in inputs stay
// stable until the one-cycle DONE state, when the pipeline advances.
//
// Parameters
//   ADDR_W      SRAM halfword address width
//   DATA_BASE   byte address that maps to SRAM halfword 0
//   ACC_CYCLES  cycles each half-access is held on the bus (>= 1)
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   mem_read_in    load request
//   mem_write_in   store request (wins if both request bits are set)
//   WB_en_in       write-back enable            -> WB_en_out   (pass-through)
//   dst_in         destination register         -> dst_out     (pass-through)
//   ALU_res_in     byte address / ALU result    -> ALU_res_out (pass-through)
//   val_Rm_in      store data
//   mem_read_out   pass-through of mem_read_in
//   mem_data_out   assembled load data, registered, holds between loads
//   ready          1 = no stall, 0 = freeze pipeline
//   sram_addr      SRAM halfword address (registered)
//   sram_dq_out    SRAM write data
//   sram_dq_oe     1 = controller drives the DQ bus
//   sram_we_n      SRAM write strobe, active low
//   sram_dq_in     SRAM read data, valid while the address is held
// -----------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
    parameter int ADDR_W     = 18,
    parameter int DATA_BASE  = 1024,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              WB_en_in,
    input  logic [3:0]        dst_in,
    input  logic [31:0]       ALU_res_in,
    input  logic [31:0]       val_Rm_in,
    output logic              WB_en_out,
    output logic              mem_read_out,
    output logic [3:0]        dst_out,
    output logic [31:0]       ALU_res_out,
    output logic [31:0]       mem_data_out,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    input  logic [15:0]       sram_dq_in
);

    localparam int              CNT_W      = (ACC_CYCLES < 2) ? 1 : $clog2(ACC_CYCLES + 1);
    localparam int              WORD_W     = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ACC_CYCLES - 1);
    localparam logic [31:0]     BASE       = 32'(DATA_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic             req;
    logic [WORD_W-1:0] word;

    // Request captured when the transaction starts.  The freeze keeps the
    // inputs stable anyway, but driving the bus from registers keeps the SRAM
    // pins a pure function of registered state.
    logic             wr_p0;
    logic             rd_p0;
    logic [31:0]      wdata_p0;

    assign req = mem_read_in | mem_write_in;

    // Word index relative to DATA_BASE; addresses below the base simply wrap.
    // The two byte-offset bits are dropped, so accesses are word aligned.
    assign word = WORD_W'((ALU_res_in - BASE) >> 2);

    // Pass-through to MEM_Stage_Reg, combinational in every state.
    assign WB_en_out    = WB_en_in;
    assign mem_read_out = mem_read_in;
    assign dst_out      = dst_in;
    assign ALU_res_out  = ALU_res_in;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // FSM next state and ready
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ready    = 1'b0;
        case (state)
            S_IDLE: begin
                // No request: zero-latency pass, the pipeline never stalls.
                ready = ~req;
                if (req) begin
                    state_nx = S_LO;
                    cnt_nx   = CNT_RELOAD;
                end
            end
            S_LO: begin
                if (cnt == '0) begin
                    state_nx = S_HI;
                    cnt_nx   = CNT_RELOAD;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_HI: begin
                if (cnt == '0) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                // The pipeline advances on this edge, so returning to IDLE
                // unconditionally cannot re-serve the same instruction.
                ready    = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Request capture, SRAM address and load-data assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_p0        <= 1'b0;
            rd_p0        <= 1'b0;
            sram_addr    <= '0;
            mem_data_out <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                // A request with both bits set is a store; the load side is
                // suppressed so mem_data_out keeps its old value.
                wr_p0     <= mem_write_in;
                rd_p0     <= mem_read_in & ~mem_write_in;
                sram_addr <= {word, 1'b0};
            end
            if (state == S_LO && cnt == '0) begin
                sram_addr[0] <= 1'b1;
                if (rd_p0) begin
                    mem_data_out[15:0] <= sram_dq_in;
                end
            end
            if (state == S_HI && cnt == '0 && rd_p0) begin
                mem_data_out[31:16] <= sram_dq_in;
            end
        end
    end

    // Store data has no reset: it only reaches the bus while wr_p0 is set,
    // and wr_p0 is only set together with a fresh capture.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            wdata_p0 <= val_Rm_in;
        end
    end

    // SRAM strobes decoded from registered state only, so they cannot glitch
    // on input changes.  A reset returns the FSM to IDLE, which releases
    // we_n on the following cycle.
    always_comb begin
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'h0000;
        if (wr_p0) begin
            case (state)
                S_LO: begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_p0[15:0];
                end
                S_HI: begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_p0[31:16];
                end
                default: begin
                    sram_we_n   = 1'b1;
                    sram_dq_oe  = 1'b0;
                    sram_dq_out = 16'h0000;
                end
            endcase
        end
    end

endmodule
